lsu_bus_ctrl: RTL and testbench
===============================

# lsu_bus_ctrl

Load/store unit that consumes the memory controls the instruction decoder emits (write enable, 3-bit `mem_ctrl` width/sign code, effective address, store data) and executes them on the single-port data bus with a request/grant/response handshake. It performs byte-lane steering, load sign/zero extension and misalignment handling. It stalls the core through a ready/valid pair and bounds every bus access with a response timeout. It sits between the core's ALU/register-file datapath and the data memory/bus fabric.

## Interface
- `TIMEOUT_CYC`, default 16: maximum cycles spent waiting for `bus_rvalid` after grant; range 2..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a memory operation.
- `req_ready`  out  1  unit is idle and accepts the operation.
- `req_we`  in  1  1 = store, 0 = load.
- `req_ctrl`  in  3  funct3 code: LOAD_B=0, LOAD_HW=1, LOAD_W=2, LOAD_BU=4, LOAD_HWU=5; STORE_B=0, STORE_HW=1, STORE_W=2.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and faults.
- `resp_fault`  out  1  qualifies `resp_valid`: timeout or misalignment trap.
- `bus_req`  out  1  bus request, held until granted.
- `bus_gnt`  in  1  bus grant.
- `bus_we`  out  1  bus write strobe.
- `bus_addr`  out  32  word address; bits [1:0] are always 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rvalid`  in  1  response or acknowledge for both loads and stores.
- `bus_rdata`  in  32  read word.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. All outputs reset to 0, except `req_ready`, which resets to 1. FSM resets to IDLE and the timeout counter resets to 0.
- IDLE: `req_ready`=1. On `req_valid`, latch we/ctrl/addr/wdata, then go to REQ, or to RESP with fault if the access is trapped.
- REQ: `bus_req`=1 with stable addr/be/wdata/we. When `bus_gnt`=1, go to WAIT and clear the counter. `bus_rvalid` in REQ is ignored.
- WAIT: `bus_req`=0. The counter increments each cycle.
  - `bus_rvalid` goes to RESP with the data captured.
  - If the counter reaches `TIMEOUT_CYC`-1 without `bus_rvalid`, go to RESP with `resp_fault`=1 and rdata 0.
  - If `bus_rvalid` and timeout occur in the same cycle, `bus_rvalid` wins (no fault).
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. `resp_*` are held stable only during this cycle.
- Byte lanes, with o = addr[1:0]:
  - Byte access: be = 1<<o; store data = byte replicated ×4.
  - Half access: be = o[1] ? 4'b1100 : 4'b0011; store data = half replicated ×2.
  - Word access: be = 4'b1111.
- Loads: select `bus_rdata` >> 8·o (byte) or >> 16·o[1] (half). LOAD_B and LOAD_HW sign-extend; LOAD_BU and LOAD_HWU zero-extend.
- Unlisted ctrl codes (loads 3/6/7, stores 3–7) execute as a word access, with no fault.
- Misaligned: a half access with o[0]=1, or a word access with o≠0. Handling is set by the Configuration macro.
- Reset asserted mid-transaction: immediate return to IDLE and `bus_req` drops asynchronously. No response is produced.

## Timing
- Minimum latency, with grant in the first REQ cycle and `bus_rvalid` in the first WAIT cycle:
  - accept at cycle 0
  - `bus_req` at cycle 1
  - `bus_rvalid` at cycle 2
  - `resp_valid` at cycle 3
- A new request can be accepted in cycle 4.
- Throughput is at most one access per 4 cycles. Each extra cycle of grant or response delay adds one cycle of latency.
- Timeout fault: `resp_valid` arrives `TIMEOUT_CYC`+1 cycles after grant.
- `bus_*` outputs come directly from registers; there is no combinational path from core request to bus.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access is accepted and issues no bus activity. `resp_valid`=1 with `resp_fault`=1 and rdata 0 on the cycle after acceptance.
- `LSU_MISALIGN_TRAP_EN` undefined: the address is force-aligned (half: clear bit 0; word: clear bits [1:0]) and the access proceeds normally with no fault.

## Structure
- The shared header `rv_defs.v` holds the LOAD_*/STORE_* codes. FSM state encodings and the misalignment predicate are also added there.
- Sub-module `lsu_align` is purely combinational. It takes ctrl, addr[1:0], wdata and rdata, and produces be, lane-replicated wdata, extended rdata and a misaligned flag. The FSM, counter and registers stay in `lsu_bus_ctrl`.

## Test plan
- Store of 0x000000AB with STORE_B at 0x1003, grant immediate, rvalid next cycle: expect bus_be=4'b1000, bus_wdata=0xABABABAB, bus_addr=0x1000, and `resp_valid` in cycle 3 with fault=0.
- Load LOAD_B at 0x2001 with bus_rdata=0x12348056: expect rdata 0xFFFFFF80. The same load with LOAD_BU: expect 0x00000080.
- Load LOAD_HW at 0x2002 with bus_rdata=0x9ABC0000: expect be=4'b1100 and rdata 0xFFFF9ABC. Hold `bus_gnt` low for 3 cycles: `bus_req` and `bus_addr` remain stable throughout.
- LOAD_W at 0x3002: with the trap macro defined, expect no `bus_req` and `resp_fault`=1 in cycle 1. Without the macro, expect bus_addr=0x3000 and a normal response.
- `TIMEOUT_CYC`=4, `bus_rvalid` never asserted: expect `resp_fault`=1 and rdata 0 four cycles after entering WAIT. Asserting rvalid on the timeout cycle instead gives no fault.
- Assert `rst_n` low during WAIT: `bus_req`, `resp_valid` and the FSM clear immediately. After release, `req_ready`=1 and a fresh store completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl_pkg
// Shared definitions for the load/store bus controller:
//   - LOAD_* / STORE_* funct3 codes as emitted by the decoder
//   - access size and FSM state encodings
//   - helpers: access size decode, misalignment predicate, load signedness
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_bus_ctrl_pkg;

   localparam logic [2:0] LOAD_B   = 3'd0;
   localparam logic [2:0] LOAD_HW  = 3'd1;
   localparam logic [2:0] LOAD_W   = 3'd2;
   localparam logic [2:0] LOAD_BU  = 3'd4;
   localparam logic [2:0] LOAD_HWU = 3'd5;

   localparam logic [2:0] STORE_B  = 3'd0;
   localparam logic [2:0] STORE_HW = 3'd1;
   localparam logic [2:0] STORE_W  = 3'd2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Any code that is not an explicit byte/half code is executed as a word.
   // Stores and loads decode differently: store code 4/5 is a word access.
   function automatic size_e access_size(input logic we, input logic [2:0] ctrl);
      size_e sz;
      if (we) begin
         case (ctrl)
            STORE_B:  sz = SZ_BYTE;
            STORE_HW: sz = SZ_HALF;
            default:  sz = SZ_WORD;
         endcase
      end else begin
         case (ctrl)
            LOAD_B, LOAD_BU:   sz = SZ_BYTE;
            LOAD_HW, LOAD_HWU: sz = SZ_HALF;
            default:           sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
      logic mis;
      case (sz)
         SZ_HALF: mis = off[0];
         SZ_WORD: mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic load_signed(input logic [2:0] ctrl);
      return (ctrl == LOAD_B) || (ctrl == LOAD_HW);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
// Ports:
//   we, ctrl      in   access direction and funct3 width/sign code
//   addr_lo       in   byte offset within the word (addr[1:0])
//   wdata         in   right-aligned store data
//   rdata         in   raw bus read word
//   be            out  byte enables for the (force-aligned) access
//   wdata_rep     out  store data replicated across the lanes
//   rdata_ext     out  selected and sign/zero-extended load data
//   off_eff       out  offset after forcing natural alignment
//   misaligned    out  raw offset violates natural alignment
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_bus_ctrl_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  ctrl,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic [1:0]  off_eff,
   output logic        misaligned
);

   genvar gi;

   logic [31:0] byte_rep;
   logic [31:0] half_rep;
   logic [31:0] lane;
   logic        sext;
   size_e       sz;

   for (gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_rep[gi*8 +: 8] = wdata[7:0];
   end

   for (gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_rep[gi*16 +: 16] = wdata[15:0];
   end

   always_comb begin
      sz         = access_size(we, ctrl);
      misaligned = is_misaligned(sz, addr_lo);
      sext       = load_signed(ctrl);

      // Lane selection always uses the naturally aligned offset, so a
      // force-aligned access steers exactly like an aligned one.
      off_eff = addr_lo;
      if (sz == SZ_HALF) off_eff[0] = 1'b0;
      if (sz == SZ_WORD) off_eff    = 2'b00;

      // One shifter covers both byte (8*o) and half (16*o[1]) selection.
      lane = rdata >> {off_eff, 3'b000};

      case (sz)
         SZ_BYTE: begin
            be        = 4'b0001 << off_eff;
            wdata_rep = byte_rep;
            rdata_ext = {{24{sext & lane[7]}}, lane[7:0]};
         end
         SZ_HALF: begin
            be        = off_eff[1] ? 4'b1100 : 4'b0011;
            wdata_rep = half_rep;
            rdata_ext = {{16{sext & lane[15]}}, lane[15:0]};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_ext = lane;
         end
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bus_ctrl
// Load/store unit executing decoder memory operations on a single-port
// request/grant/response data bus, with lane steering, load extension,
// misalignment handling and a bounded response wait.
// Parameter:
//   TIMEOUT_CYC   cycles waited for bus_rvalid after grant (2..255)
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined: misaligned accesses fault without bus
//                         activity; undefined: address is force-aligned.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              core handshake (ready = idle)
//   req_we, req_ctrl, req_addr,
//   req_wdata                        memory operation from the decoder
//   resp_valid, resp_rdata,
//   resp_fault                       one-cycle completion to the core
//   bus_req/bus_gnt                  bus arbitration
//   bus_we, bus_addr, bus_be,
//   bus_wdata                        registered bus command
//   bus_rvalid, bus_rdata            bus response / store acknowledge
// -----------------------------------------------------------------------------
module lsu_bus_ctrl
   import lsu_bus_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_ctrl,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic        bus_req_q, bus_req_d;

   // The steering unit is shared: in IDLE it looks at the incoming request
   // (be / lane data / alignment), afterwards at the latched operation so it
   // can extract the load result from bus_rdata.
   logic        is_idle;
   logic        al_we;
   logic [2:0]  al_ctrl;
   logic [1:0]  al_addr_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic [1:0]  al_off;
   logic        al_misaligned;

   assign is_idle    = (state_q == ST_IDLE);
   assign al_we      = is_idle ? req_we        : we_q;
   assign al_ctrl    = is_idle ? req_ctrl      : ctrl_q;
   assign al_addr_lo = is_idle ? req_addr[1:0] : addr_q[1:0];

   lsu_align u_align (
      .we         (al_we),
      .ctrl       (al_ctrl),
      .addr_lo    (al_addr_lo),
      .wdata      (req_wdata),
      .rdata      (bus_rdata),
      .be         (al_be),
      .wdata_rep  (al_wdata),
      .rdata_ext  (al_rdata),
      .off_eff    (al_off),
      .misaligned (al_misaligned)
   );

`ifndef LSU_MISALIGN_TRAP_EN
   // With force-alignment the misaligned flag has no consumer.
   logic unused_misaligned;
   assign unused_misaligned = al_misaligned;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         we_q      <= 1'b0;
         ctrl_q    <= 3'd0;
         addr_q    <= 32'd0;
         be_q      <= 4'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         fault_q   <= 1'b0;
         bus_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         ctrl_q    <= ctrl_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         fault_q   <= fault_d;
         bus_req_q <= bus_req_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      ctrl_d  = ctrl_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               fault_d = 1'b0;
               rdata_d = 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
               if (al_misaligned) begin
                  // Bus command registers are left untouched: no bus activity.
                  state_d = ST_RESP;
                  fault_d = 1'b1;
               end else
`endif
               begin
                  state_d = ST_REQ;
                  we_d    = req_we;
                  ctrl_d  = req_ctrl;
                  addr_d  = {req_addr[31:2], al_off};
                  be_d    = al_be;
                  wdata_d = al_wdata;
               end
            end
         end
         ST_REQ: begin
            if (bus_gnt) begin
               state_d = ST_WAIT;
               cnt_d   = 8'd0;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A response on the last allowed cycle still counts as success.
            if (bus_rvalid) begin
               state_d = ST_RESP;
               rdata_d = we_q ? 32'd0 : al_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               fault_d = 1'b1;
               rdata_d = 32'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered so bus_req never depends combinationally on the core.
      bus_req_d = (state_d == ST_REQ);
   end

   // Outputs
   always_comb begin
      req_ready  = is_idle;
      resp_valid = (state_q == ST_RESP);
      resp_fault = resp_valid & fault_q;
      resp_rdata = resp_valid ? rdata_q : 32'd0;
      bus_req    = bus_req_q;
      bus_we     = we_q;
      bus_addr   = {addr_q[31:2], 2'b00};
      bus_be     = be_q;
      bus_wdata  = wdata_q;
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

   localparam int T     = 4;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_ctrl = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   always #5 clk = ~clk;

   lsu_bus_ctrl #(.TIMEOUT_CYC(T)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_ctrl   (req_ctrl),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brd;
      int          gnt_dly;
      int          rv_dly;
      logic        rv_in_req;
      logic        trap;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } resp_t;

   resp_t sb_q[$];
   vec_t  vecs[15];
   int    total = 0;
   int    bad = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] ctrl,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] brd, input int g, input int rv,
                               input logic rvreq, input logic trap, input logic [3:0] be,
                               input logic [31:0] eaddr, input logic [31:0] ewdata,
                               input logic [31:0] erdata, input logic efault);
      vec_t v;
      v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.brd = brd;
      v.gnt_dly = g; v.rv_dly = rv; v.rv_in_req = rvreq; v.trap = trap;
      v.exp_be = be; v.exp_addr = eaddr; v.exp_wdata = ewdata;
      v.exp_rdata = erdata; v.exp_fault = efault;
      return v;
   endfunction

   // Scoreboard: every completion pulse must match the oldest expectation.
   always @(negedge clk) begin
      resp_t e;
      if (rst_n && resp_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got resp_valid=1 want none");
         end else begin
            e = sb_q.pop_front();
            check32("resp_rdata", resp_rdata, e.rdata);
            check32("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check32("req_ready_idle", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  exp_lat;
      int  lat;
      int  g;
      bit  seen;
      resp_t e;
      g = v.gnt_dly;
      wait_ready();
      req_valid = 1'b1;
      req_we    = v.we;
      req_ctrl  = v.ctrl;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      bus_rdata = v.brd;
      e.rdata = v.exp_rdata;
      e.fault = v.exp_fault;
      sb_q.push_back(e);
      if (v.trap)                exp_lat = 1;
      else if (v.rv_dly == NEVER) exp_lat = 2 + g + T;
      else                        exp_lat = 3 + g + v.rv_dly;
      seen = 0;
      lat  = 0;
      for (int k = 1; k <= 100 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         if (v.trap && k == 1)
            check32("trap_no_bus_req", {31'd0, bus_req}, 32'd0);
         if (resp_valid) begin
            seen = 1;
            lat  = k;
         end else if (!v.trap) begin
            if (k <= 1 + g) begin
               check32("bus_req_held", {31'd0, bus_req}, 32'd1);
               check32("bus_addr", bus_addr, v.exp_addr);
               check32("bus_be", {28'd0, bus_be}, {28'd0, v.exp_be});
               check32("bus_we", {31'd0, bus_we}, {31'd0, v.we});
               if (v.we) check32("bus_wdata", bus_wdata, v.exp_wdata);
               bus_gnt    = (k == 1 + g);
               bus_rvalid = v.rv_in_req && (k <= g);
            end else begin
               if (k == 2 + g) check32("bus_req_drop", {31'd0, bus_req}, 32'd0);
               if (v.rv_dly != NEVER && k == 2 + g + v.rv_dly) bus_rvalid = 1'b1;
            end
         end
      end
      check32("resp_latency", lat, exp_lat);
      $display("txn %0d we=%0d ctrl=%0d addr=%h latency=%0d rdata=%h fault=%0d",
               idx, v.we, v.ctrl, v.addr, lat, resp_rdata, resp_fault);
      @(negedge clk);
      check32("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
   endtask

   // Reset while in REQ (phase 1) or WAIT (phase 2): everything clears at once.
   task automatic reset_mid(input int phase);
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_ctrl  = 3'd2;
      req_addr  = 32'h0000A000 + 32'(phase * 4);
      @(negedge clk);
      req_valid = 1'b0;
      check32("rst_pre_bus_req", {31'd0, bus_req}, 32'd1);
      if (phase == 2) begin
         bus_gnt = 1'b1;
         @(negedge clk);
         bus_gnt = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check32("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check32("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check32("rst_bus_addr", bus_addr, 32'd0);
      $display("txn reset phase=%0d bus_req=%0d req_ready=%0d", phase, bus_req, req_ready);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = mk(1, 3'd0, 32'h00001003, 32'h000000AB, 32'h0, 0, 0, 0, 0,
                    4'b1000, 32'h00001000, 32'hABABABAB, 32'h0, 0);
      vecs[1]  = mk(0, 3'd0, 32'h00002001, 32'h0, 32'h12348056, 0, 0, 0, 0,
                    4'b0010, 32'h00002000, 32'h0, 32'hFFFFFF80, 0);
      vecs[2]  = mk(0, 3'd4, 32'h00002001, 32'h0, 32'h12348056, 0, 0, 0, 0,
                    4'b0010, 32'h00002000, 32'h0, 32'h00000080, 0);
      vecs[3]  = mk(0, 3'd1, 32'h00002002, 32'h0, 32'h9ABC0000, 3, 0, 0, 0,
                    4'b1100, 32'h00002000, 32'h0, 32'hFFFF9ABC, 0);
      vecs[4]  = mk(0, 3'd5, 32'h00002002, 32'h0, 32'h9ABC0000, 0, 2, 0, 0,
                    4'b1100, 32'h00002000, 32'h0, 32'h00009ABC, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[5]  = mk(0, 3'd2, 32'h00003002, 32'h0, 32'hCAFEF00D, 0, 0, 0, 1,
                    4'b0000, 32'h0, 32'h0, 32'h0, 1);
      vecs[10] = mk(0, 3'd1, 32'h00007001, 32'h0, 32'h00008001, 0, 0, 0, 1,
                    4'b0000, 32'h0, 32'h0, 32'h0, 1);
`else
      vecs[5]  = mk(0, 3'd2, 32'h00003002, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0,
                    4'b1111, 32'h00003000, 32'h0, 32'hCAFEF00D, 0);
      vecs[10] = mk(0, 3'd1, 32'h00007001, 32'h0, 32'h00008001, 0, 0, 0, 0,
                    4'b0011, 32'h00007000, 32'h0, 32'hFFFF8001, 0);
`endif
      vecs[6]  = mk(0, 3'd2, 32'h00004000, 32'h0, 32'h55555555, 0, NEVER, 0, 0,
                    4'b1111, 32'h00004000, 32'h0, 32'h0, 1);
      vecs[7]  = mk(0, 3'd2, 32'h00004004, 32'h0, 32'h11223344, 0, T - 1, 0, 0,
                    4'b1111, 32'h00004004, 32'h0, 32'h11223344, 0);
      vecs[8]  = mk(1, 3'd1, 32'h00005002, 32'h1234BEEF, 32'h0, 1, 1, 0, 0,
                    4'b1100, 32'h00005000, 32'hBEEFBEEF, 32'h0, 0);
      vecs[9]  = mk(1, 3'd2, 32'h00006000, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0,
                    4'b1111, 32'h00006000, 32'hDEADBEEF, 32'h0, 0);
      vecs[11] = mk(0, 3'd3, 32'h00008000, 32'h0, 32'h87654321, 0, 0, 0, 0,
                    4'b1111, 32'h00008000, 32'h0, 32'h87654321, 0);
      vecs[12] = mk(1, 3'd5, 32'h00008004, 32'h000000FF, 32'h0, 0, 0, 0, 0,
                    4'b1111, 32'h00008004, 32'h000000FF, 32'h0, 0);
      vecs[13] = mk(0, 3'd0, 32'h00009003, 32'h0, 32'h7F000000, 2, 0, 1, 0,
                    4'b1000, 32'h00009000, 32'h0, 32'h0000007F, 0);
      vecs[14] = mk(0, 3'd4, 32'h00009000, 32'h0, 32'h000000FE, 0, 1, 0, 0,
                    4'b0001, 32'h00009000, 32'h0, 32'h000000FE, 0);

      repeat (2) @(negedge clk);
      check32("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check32("reset_bus_req", {31'd0, bus_req}, 32'd0);
      check32("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check32("reset_resp_fault", {31'd0, resp_fault}, 32'd0);
      check32("reset_resp_rdata", resp_rdata, 32'd0);
      check32("reset_bus_we", {31'd0, bus_we}, 32'd0);
      check32("reset_bus_addr", bus_addr, 32'd0);
      check32("reset_bus_be", {28'd0, bus_be}, 32'd0);
      check32("reset_bus_wdata", bus_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      reset_mid(1);
      reset_mid(2);
      run_vec(mk(1, 3'd0, 32'h0000B002, 32'h00000042, 32'h0, 0, 0, 0, 0,
                 4'b0100, 32'h0000B000, 32'h42424242, 32'h0, 0), 15);

      repeat (2) @(negedge clk);
      check32("scoreboard_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
